pwm_bank_shadowed: RTL
======================

// Module: pwm_bank_shadowed
// PURPOSE
//   Parametrised N-channel PWM generator with double-buffered duty registers.
//   Duty writes arrive over a valid/ready port from the SPI deserializer path.
//   Each write lands in a per-channel pending register. All pending registers
//   commit to the active set together at a period boundary, so no glitched
//   periods are produced. Outputs drive the lamp LED power pins.
// PARAMETERS
//   CHANNELS  4  number of PWM channels (>=1)
//   WIDTH     8  duty/counter width; period = 2^WIDTH-1 ticks
//   PRESC_W   4  width of the prescaler divide input
// PORTS
//   clk           in   1                   system clock
//   reset         in   1                   async, active-high; clears all state
//   enable        in   1                   run PWM when high
//   presc_div     in   PRESC_W             tick every presc_div+1 clk cycles
//   wr_valid      in   1                   duty write request
//   wr_ready      out  1                   write accepted when valid&ready
//   wr_chan       in   max(1,clog2(CH))    target channel index
//   wr_duty       in   WIDTH               new duty; 0=off, 2^WIDTH-1=full on
//   pwm_out       out  CHANNELS            registered PWM outputs
//   period_start  out  1                   1-clk pulse when a new period begins
// BEHAVIOUR
//   Reset: all outputs are 0. All pending, active and counter registers are 0.
//     The FSM is in IDLE. wr_ready is 0 while reset is high.
//   FSM has three states:
//     IDLE: counters held at 0; pwm_out=0; wr_ready=1.
//       enable=1 -> SYNC.
//     SYNC: exactly 1 cycle. active<=pending, presc_cnt<=0, cnt<=0.
//       Next state is RUN.
//     RUN: counting.
//       enable=0 -> IDLE on the next clk. pwm_out is 0 from the cycle after
//       enable is sampled low.
//   Prescaler: tick=1 when presc_cnt==presc_div, and presc_cnt then returns
//     to 0. presc_div=0 means a tick on every clk. A change to presc_div takes
//     effect at the next compare.
//   Period counter: advances on each tick through 0..2^WIDTH-2, then wraps
//     to 0 (the wrap event).
//   Commit: on the wrap tick, active<=pending for all channels, and
//     period_start pulses in the same cycle that cnt becomes 0. SYNC also
//     pulses period_start.
//   Output: pwm_out[i] <= (cnt_cmp_i < active[i]), registered, so pwm_out lags
//     cnt by 1 clk. Duty 0 never goes high. Duty 2^WIDTH-1 never goes low.
//   Write: accepted when wr_valid&wr_ready; pending[wr_chan]<=wr_duty.
//     wr_ready=0 only in the commit cycle (wrap tick or SYNC). A stalled
//       write is held by the source and accepted on the next cycle.
//     An out-of-range wr_chan (>=CHANNELS) is acknowledged and discarded.
//     Several writes in one period: last write wins.
//     Writes in IDLE update pending only and are committed by SYNC.
//   Reset mid-period forces IDLE immediately. Pending values are lost.
// CONFIGURATION
//   PWM_PHASE_STAGGER_EN defined:
//     cnt_cmp_i = (cnt + i*((2^WIDTH-1)/CHANNELS)) mod (2^WIDTH-1).
//     This spreads rising edges across the period to cut supply inrush.
//     Duty-cycle ratio per channel is unchanged.
//   PWM_PHASE_STAGGER_EN undefined: cnt_cmp_i = cnt for all i, so all
//     channels rise together at the period start.
// TESTING
//   1) Reset, then enable=1, presc_div=0, write ch0=0x80:
//      pwm_out[0] is high for 128 of every 255 clks; period_start pulses
//      every 255 clks.
//   2) Write duty 0x00 to ch1 and 0xFF to ch2: ch1 stays constantly 0 and
//      ch2 stays constantly 1 across 3 periods.
//   3) Mid-period, write ch0 from 0x40 to 0xC0: the current period still
//      shows 64 high clks; the next period shows 192.
//   4) Hold wr_valid on the wrap tick: wr_ready is 0 for exactly 1 clk, the
//      write is accepted on the next clk, and it commits one period later.
//   5) presc_div=3, ch3=0x10: high for 64 clks, period 1020 clks.
//      Then enable=0 mid-period: all outputs are 0 within 2 clks.
//      Assert reset async: all outputs are 0 with no clk edge.
//   6) With PWM_PHASE_STAGGER_EN, CH=4, all duties 0x20: the four rising
//      edges are 63 ticks apart, and each channel has 32 high ticks.

Source files
------------

// File: rtl/pwm_bank_shadowed.sv
// N-channel PWM bank with shadowed duty registers; define PWM_PHASE_STAGGER_EN to stagger channel phases.
// Latency: pwm_out is registered one clk behind the period counter; duty writes show from the next period.
// Backpressure: wr_ready drops only in the commit cycle (wrap tick or SYNC); a held write lands one clk later.
module pwm_bank_shadowed #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int PRESC_W  = 4,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PRESC_W-1:0]  presc_div,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [CW-1:0]       wr_chan,
    input  logic [WIDTH-1:0]    wr_duty,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int              PERIOD   = (1 << WIDTH) - 1;
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(PERIOD - 1);

    state_t              state;
    state_t              state_nxt;
    logic [PRESC_W-1:0]  presc_cnt;
    logic [WIDTH-1:0]    cnt;
    logic [WIDTH-1:0]    pending [CHANNELS];
    logic [WIDTH-1:0]    active  [CHANNELS];
    logic [CHANNELS-1:0] pwm_nxt;
    logic                run;
    logic                tick;
    logic                wrap;
    logic                commit;
    logic                wr_fire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        run       = 1'b0;
        tick      = 1'b0;
        wrap      = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_nxt = SYNC;
            end
            SYNC: begin
                state_nxt = RUN;
                commit    = 1'b1;
            end
            RUN: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else begin
                    run    = 1'b1;
                    tick   = (presc_cnt == presc_div);
                    wrap   = tick && (cnt == CNT_LAST);
                    commit = wrap;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Blocking writes during commit keeps pending stable while it is copied to active.
    assign wr_ready = !reset && !commit;
    assign wr_fire  = wr_valid && wr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_cnt    <= '0;
            cnt          <= '0;
            pwm_out      <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= commit;
            pwm_out      <= run ? pwm_nxt : '0;
            if (!run) begin
                presc_cnt <= '0;
                cnt       <= '0;
            end else if (tick) begin
                presc_cnt <= '0;
                cnt       <= wrap ? '0 : cnt + 1'b1;
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end
        end
    end

    // Out-of-range channel indices match no slot, so such writes are acked and dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (commit) active[i] <= pending[i];
                if (wr_fire && (wr_chan == CW'(i))) pending[i] <= wr_duty;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] cmp;
`ifdef PWM_PHASE_STAGGER_EN
        // Offset is below PERIOD, so a single conditional subtract does the modulo.
        localparam int OFF = i * (PERIOD / CHANNELS);
        logic [WIDTH:0] sum;
        assign sum = {1'b0, cnt} + (WIDTH+1)'(OFF);
        assign cmp = (sum >= (WIDTH+1)'(PERIOD)) ? WIDTH'(sum - (WIDTH+1)'(PERIOD))
                                                : sum[WIDTH-1:0];
`else
        assign cmp = cnt;
`endif
        assign pwm_nxt[i] = (cmp < active[i]);
    end

endmodule
